// File: rtl/matrix_engine_pkg.sv
// Shared definitions for the 4x4 16-bit matrix engine and its sequencer:
// op codes, engine control codes, matrix word type and sequencer states.
package matrix_engine_pkg;

  localparam int MAT_W  = 256;
  localparam int ELEM_W = 16;

  typedef logic [MAT_W-1:0] mat_t;

  // Engine op codes
  localparam logic [2:0] NO_OP     = 3'b000;
  localparam logic [2:0] LOAD      = 3'b001;
  localparam logic [2:0] ADD       = 3'b010;
  localparam logic [2:0] SUB       = 3'b011;
  localparam logic [2:0] SCAL_MUL  = 3'b100;
  localparam logic [2:0] MATR_MUL  = 3'b101;
  localparam logic [2:0] TRANSPOSE = 3'b110;
  localparam logic [2:0] STOP      = 3'b111;

  // Engine alu_control codes
  localparam logic [2:0] CTRL_NONE   = 3'b000;
  localparam logic [2:0] CTRL_LOAD_A = 3'b001;
  localparam logic [2:0] CTRL_C2A    = 3'b010;
  localparam logic [2:0] CTRL_LOAD_B = 3'b100;
  localparam logic [2:0] CTRL_OUT    = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH_A = 4'd1,
    S_LOAD_A  = 4'd2,
    S_C2A     = 4'd3,
    S_FETCH_B = 4'd4,
    S_LOAD_B  = 4'd5,
    S_EXEC    = 4'd6,
    S_READ    = 4'd7,
    S_WRITE   = 4'd8,
    S_DONE    = 4'd9
  } seq_state_e;

  // Commands the sequencer can run end to end (ADD..TRANSPOSE)
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= ADD) && (op <= TRANSPOSE);
  endfunction

  // Two-operand commands need B fetched from memory
  function automatic logic needs_b(input logic [2:0] op);
    return (op == ADD) || (op == SUB) || (op == MATR_MUL);
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// Command, memory and engine-control signals of the matrix op sequencer.
// The shared tristate data bus is kept as a plain inout on the module.
interface matrix_op_sequencer_if #(
  parameter int ADDR_W = 8
);
  import matrix_engine_pkg::*;

  // command side
  logic              start;
  logic [2:0]        cmd_op;
  logic              cmd_chain;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_c;
  logic              busy;
  logic              done;
  logic              err;
  // matrix memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  mat_t              mem_rdata;
  logic              mem_wr;
  mat_t              mem_wdata;
  // engine control side
  logic [2:0]        op_code;
  logic [2:0]        alu_control;
  logic              n_alu_enable;

  modport master (
    input  start, cmd_op, cmd_chain, addr_a, addr_b, addr_c, mem_rdata,
    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata,
           op_code, alu_control, n_alu_enable
  );

  modport slave (
    output start, cmd_op, cmd_chain, addr_a, addr_b, addr_c, mem_rdata,
    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata,
           op_code, alu_control, n_alu_enable
  );

endinterface

// File: rtl/matrix_op_sequencer.sv
// Bus master that runs one matrix-engine command end to end: fetch A (or
// copy C->A), fetch B when needed, load the engine, execute, read C back
// off the shared bus and store it to memory. All outputs are registered
// by decoding the next state.
module matrix_op_sequencer
  import matrix_engine_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  matrix_op_sequencer_if.master  bus,
  inout  wire  [MAT_W-1:0]       data_bus
);

  seq_state_e        r_state;
  seq_state_e        w_next;
  // addr_a and cmd_chain are consumed at the accepting edge itself, so only
  // the op and the later-used addresses need holding registers.
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr_b;
  logic [ADDR_W-1:0] r_addr_c;
  logic              r_drive;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  mat_t              r_mem_wdata;   // holds the result captured off the bus
  logic [2:0]        r_op_code;
  logic [2:0]        r_alu_control;
  logic              r_n_alu_enable;

  // Next-state decode of the command sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.start) begin
          w_next = S_IDLE;
        end else if (!is_legal_op(bus.cmd_op)) begin
          w_next = S_DONE;
        end else if (bus.cmd_chain) begin
          w_next = S_C2A;
        end else begin
          w_next = S_FETCH_A;
        end
      end
      S_FETCH_A:        w_next = S_LOAD_A;
      S_LOAD_A, S_C2A:  w_next = needs_b(r_op) ? S_FETCH_B : S_EXEC;
      S_FETCH_B:        w_next = S_LOAD_B;
      S_LOAD_B:         w_next = S_EXEC;
      S_EXEC:           w_next = S_READ;
      S_READ:           w_next = S_WRITE;
      S_WRITE:          w_next = S_DONE;
      S_DONE:           w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  // State, command capture and registered outputs for the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= NO_OP;
      r_addr_b       <= {ADDR_W{1'b0}};
      r_addr_c       <= {ADDR_W{1'b0}};
      r_drive        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_mem_addr     <= {ADDR_W{1'b0}};
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_mem_wdata    <= {MAT_W{1'b0}};
      r_op_code      <= NO_OP;
      r_alu_control  <= CTRL_NONE;
      r_n_alu_enable <= 1'b1;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && bus.start) begin
        r_op     <= bus.cmd_op;
        r_addr_b <= bus.addr_b;
        r_addr_c <= bus.addr_c;
      end
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      // DONE reached from WRITE is always a legal command
      r_err       <= (r_state == S_IDLE) && bus.start && !is_legal_op(bus.cmd_op);
      r_mem_rd    <= (w_next == S_FETCH_A) || (w_next == S_FETCH_B);
      r_mem_wr    <= (w_next == S_WRITE);
      r_drive     <= (w_next == S_LOAD_A) || (w_next == S_LOAD_B);
      // only READ leads to WRITE, so this samples the engine's result
      r_mem_wdata <= (w_next == S_WRITE) ? mat_t'(data_bus) : {MAT_W{1'b0}};

      r_mem_addr     <= {ADDR_W{1'b0}};
      r_op_code      <= NO_OP;
      r_alu_control  <= CTRL_NONE;
      r_n_alu_enable <= 1'b1;
      case (w_next)
        S_FETCH_A: r_mem_addr <= bus.addr_a;
        S_LOAD_A: begin
          r_op_code      <= LOAD;
          r_alu_control  <= CTRL_LOAD_A;
          r_n_alu_enable <= 1'b0;
        end
        S_C2A: begin
          r_op_code      <= LOAD;
          r_alu_control  <= CTRL_C2A;
          r_n_alu_enable <= 1'b0;
        end
        S_FETCH_B: r_mem_addr <= r_addr_b;
        S_LOAD_B: begin
          r_op_code      <= LOAD;
          r_alu_control  <= CTRL_LOAD_B;
          r_n_alu_enable <= 1'b0;
        end
        S_EXEC, S_READ: begin
          r_op_code      <= r_op;
          r_alu_control  <= CTRL_OUT;
          r_n_alu_enable <= 1'b0;
        end
        S_WRITE:   r_mem_addr <= r_addr_c;
        default:   r_mem_addr <= {ADDR_W{1'b0}};
      endcase
    end
  end

  // Bus is driven with memory read data only while loading A or B
  assign data_bus = r_drive ? bus.mem_rdata : {MAT_W{1'bz}};

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.op_code      = r_op_code;
  assign bus.alu_control  = r_alu_control;
  assign bus.n_alu_enable = r_n_alu_enable;

endmodule
